// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, HI/LO multiply/divide and the EX/MEM pipeline register.
// Define EX_DIV_EN to build the iterative DIVU unit; without it DIVU is a no-op and stall_o is 0.
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32,
    localparam int unsigned XLEN = DIV_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rs_i,
    input  logic [4:0]      rt_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      shamt_i,
    input  logic            regdst_i,
    input  logic [3:0]      aluop_i,
    input  logic [1:0]      alusrca_i,
    input  logic [1:0]      alusrcb_i,
    input  logic            mem2reg_i,
    input  logic            regwr_i,
    input  logic            memwr_i,
    input  logic [XLEN-1:0] fwd_mem_data_i,
    input  logic [4:0]      fwd_mem_reg_i,
    input  logic            fwd_mem_wr_i,
    input  logic [XLEN-1:0] fwd_wb_data_i,
    input  logic [4:0]      fwd_wb_reg_i,
    input  logic            fwd_wb_wr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] alu_res_o,
    output logic [XLEN-1:0] st_data_o,
    output logic [4:0]      wr_reg_o,
    output logic            mem2reg_o,
    output logic            regwr_o,
    output logic            memwr_o
);

    localparam int unsigned PW = 2 * XLEN;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_MFHI = 4'd14;
    localparam logic [3:0] OP_MFLO = 4'd15;

    logic [XLEN-1:0] rs_fwd;
    logic [XLEN-1:0] rt_fwd;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            stall;
    logic            div_commit;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;

    // MEM result wins over WB; register 0 is never forwarded
    always_comb begin
        rs_fwd = rs_data_i;
        rt_fwd = rt_data_i;
        if (fwd_mem_wr_i && fwd_mem_reg_i == rs_i && rs_i != 5'd0) begin
            rs_fwd = fwd_mem_data_i;
        end else if (fwd_wb_wr_i && fwd_wb_reg_i == rs_i && rs_i != 5'd0) begin
            rs_fwd = fwd_wb_data_i;
        end
        if (fwd_mem_wr_i && fwd_mem_reg_i == rt_i && rt_i != 5'd0) begin
            rt_fwd = fwd_mem_data_i;
        end else if (fwd_wb_wr_i && fwd_wb_reg_i == rt_i && rt_i != 5'd0) begin
            rt_fwd = fwd_wb_data_i;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (alusrca_i)
            2'd0:    op_a = rs_fwd;
            2'd1:    op_a = XLEN'(shamt_i);
            2'd2:    op_a = pc4_i;
            default: op_a = '0;
        endcase
        case (alusrcb_i)
            2'd0:    op_b = rt_fwd;
            2'd1:    op_b = imm_i;
            2'd2:    op_b = XLEN'(4);
            default: op_b = '0;
        endcase
    end

    assign prod = PW'(op_a) * PW'(op_b);

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_res = XLEN'(op_a < op_b);
            OP_SLL:  alu_res = op_b << op_a[4:0];
            OP_SRL:  alu_res = op_b >> op_a[4:0];
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
            OP_LUI:  alu_res = XLEN'({op_b[15:0], 16'h0000});
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    div_state_e      div_state;
    logic [CNT_W-1:0] div_cnt;
    logic [XLEN-1:0] div_dsr;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;
    logic            div_start;

    // Stall must be visible in the same cycle DIVU reaches EX so ID/EX keeps holding it
    assign div_start  = (div_state == DIV_IDLE) && (aluop_i == OP_DIVU) && !flush_i && !rst;
    assign stall      = div_start || (div_state == DIV_BUSY);
    assign div_commit = (div_state == DIV_DONE) && !flush_i;
    assign div_shift  = {div_rem, div_quo[XLEN-1]};
    assign div_ge     = div_shift >= {1'b0, div_dsr};
    assign div_sub    = div_shift[XLEN-1:0] - div_dsr;

    // Restoring divider, one quotient bit per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            div_dsr   <= '0;
            div_quo   <= '0;
            div_rem   <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        div_quo   <= op_a;
                        div_dsr   <= op_b;
                        div_rem   <= '0;
                        div_cnt   <= '0;
                        div_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (flush_i) begin
                        div_state <= DIV_IDLE;
                    end else begin
                        div_rem <= div_ge ? div_sub : div_shift[XLEN-1:0];
                        div_quo <= {div_quo[XLEN-2:0], div_ge};
                        div_cnt <= div_cnt + CNT_W'(1);
                        if (div_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                            div_state <= DIV_DONE;
                        end
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end
`else
    assign stall      = 1'b0;
    assign div_commit = 1'b0;
    assign div_quo    = '0;
    assign div_rem    = '0;
`endif

    assign stall_o = stall;

    // HI/LO: divider result on leaving DONE, MULTU product on its own committing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_commit) begin
            hi <= div_rem;
            lo <= div_quo;
        end else if (aluop_i == OP_MULTU && !flush_i && !stall) begin
            hi <= prod[PW-1:XLEN];
            lo <= prod[XLEN-1:0];
        end
    end

    // EX/MEM pipeline register; stall or flush inserts a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_o <= '0;
            st_data_o <= '0;
            wr_reg_o  <= '0;
            mem2reg_o <= 1'b0;
            regwr_o   <= 1'b0;
            memwr_o   <= 1'b0;
        end else if (flush_i || stall) begin
            alu_res_o <= '0;
            st_data_o <= '0;
            wr_reg_o  <= '0;
            mem2reg_o <= 1'b0;
            regwr_o   <= 1'b0;
            memwr_o   <= 1'b0;
        end else begin
            alu_res_o <= alu_res;
            st_data_o <= rt_fwd;
            wr_reg_o  <= regdst_i ? rd_i : rt_i;
            mem2reg_o <= mem2reg_i;
            regwr_o   <= regwr_i;
            memwr_o   <= memwr_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divider scenarios are built when EX_DIV_EN is defined.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc4_i, rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic        regdst_i;
    logic [3:0]  aluop_i;
    logic [1:0]  alusrca_i, alusrcb_i;
    logic        mem2reg_i, regwr_i, memwr_i;
    logic [31:0] fwd_mem_data_i, fwd_wb_data_i;
    logic [4:0]  fwd_mem_reg_i, fwd_wb_reg_i;
    logic        fwd_mem_wr_i, fwd_wb_wr_i, flush_i;
    logic        stall_o;
    logic [31:0] alu_res_o, st_data_o;
    logic [4:0]  wr_reg_o;
    logic        mem2reg_o, regwr_o, memwr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .regdst_i(regdst_i), .aluop_i(aluop_i), .alusrca_i(alusrca_i), .alusrcb_i(alusrcb_i),
        .mem2reg_i(mem2reg_i), .regwr_i(regwr_i), .memwr_i(memwr_i),
        .fwd_mem_data_i(fwd_mem_data_i), .fwd_mem_reg_i(fwd_mem_reg_i), .fwd_mem_wr_i(fwd_mem_wr_i),
        .fwd_wb_data_i(fwd_wb_data_i), .fwd_wb_reg_i(fwd_wb_reg_i), .fwd_wb_wr_i(fwd_wb_wr_i),
        .flush_i(flush_i), .stall_o(stall_o), .alu_res_o(alu_res_o), .st_data_o(st_data_o),
        .wr_reg_o(wr_reg_o), .mem2reg_o(mem2reg_o), .regwr_o(regwr_o), .memwr_o(memwr_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc4_i = '0; rs_data_i = '0; rt_data_i = '0; imm_i = '0;
        rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0; regdst_i = 1'b0;
        aluop_i = 4'd0; alusrca_i = 2'd0; alusrcb_i = 2'd0;
        mem2reg_i = 1'b0; regwr_i = 1'b0; memwr_i = 1'b0;
        fwd_mem_data_i = '0; fwd_mem_reg_i = '0; fwd_mem_wr_i = 1'b0;
        fwd_wb_data_i = '0; fwd_wb_reg_i = '0; fwd_wb_wr_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        idle_inputs();
        aluop_i = op; rs_i = 5'd1; rt_i = 5'd2; rd_i = 5'd3; regdst_i = 1'b1; regwr_i = 1'b1;
        rs_data_i = a; rt_data_i = b;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({alu_res_o, st_data_o, wr_reg_o, mem2reg_o, regwr_o, memwr_o, stall_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs got res=%h st=%h reg=%0d ctl=%b%b%b stall=%b exp all 0",
                     alu_res_o, st_data_o, wr_reg_o, mem2reg_o, regwr_o, memwr_o, stall_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        idle_inputs();
        aluop_i = 4'd0; rs_i = 5'd5; rt_i = 5'd6; rd_i = 5'd7; rs_data_i = 32'd3; rt_data_i = 32'd4;
        regdst_i = 1'b1; regwr_i = 1'b1;
        step();
        checks++;
        if (alu_res_o !== 32'd7 || wr_reg_o !== 5'd7 || regwr_o !== 1'b1 || st_data_o !== 32'd4) begin
            errors++;
            $display("FAIL add got res=%h reg=%0d regwr=%b st=%h exp 7/7/1/4",
                     alu_res_o, wr_reg_o, regwr_o, st_data_o);
        end
        regdst_i = 1'b0; mem2reg_i = 1'b1; memwr_i = 1'b1; regwr_i = 1'b0;
        step();
        checks++;
        if (wr_reg_o !== 5'd6 || {mem2reg_o, regwr_o, memwr_o} !== 3'b101) begin
            errors++;
            $display("FAIL regdst_rt got reg=%0d ctl=%b%b%b exp 6 101", wr_reg_o, mem2reg_o, regwr_o, memwr_o);
        end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        aluop_i = 4'd0; alusrcb_i = 2'd3; regwr_i = 1'b1;
        rs_i = 5'd8; rs_data_i = 32'd5; rt_i = 5'd8; rt_data_i = 32'd6;
        fwd_mem_reg_i = 5'd8; fwd_mem_data_i = 32'd10; fwd_mem_wr_i = 1'b1;
        fwd_wb_reg_i = 5'd8; fwd_wb_data_i = 32'd20; fwd_wb_wr_i = 1'b1;
        step();
        checks++;
        if (alu_res_o !== 32'd10 || st_data_o !== 32'd10) begin
            errors++;
            $display("FAIL fwd_mem_prio got a=%h st=%h exp 10/10", alu_res_o, st_data_o);
        end
        fwd_mem_wr_i = 1'b0;
        step();
        checks++;
        if (alu_res_o !== 32'd20 || st_data_o !== 32'd20) begin
            errors++;
            $display("FAIL fwd_wb got a=%h st=%h exp 20/20", alu_res_o, st_data_o);
        end
        fwd_mem_wr_i = 1'b1; fwd_mem_reg_i = 5'd9; fwd_wb_wr_i = 1'b0;
        step();
        checks++;
        if (alu_res_o !== 32'd5 || st_data_o !== 32'd6) begin
            errors++;
            $display("FAIL fwd_none got a=%h st=%h exp 5/6", alu_res_o, st_data_o);
        end
        rs_i = 5'd0; rt_i = 5'd0; fwd_mem_reg_i = 5'd0; fwd_wb_reg_i = 5'd0;
        fwd_mem_wr_i = 1'b1; fwd_wb_wr_i = 1'b1;
        step();
        checks++;
        if (alu_res_o !== 32'd5 || st_data_o !== 32'd6) begin
            errors++;
            $display("FAIL fwd_reg0 got a=%h st=%h exp 5/6", alu_res_o, st_data_o);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    task automatic test_alu_ops();
        vec_t v[15];
        v = '{
            '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE},
            '{4'd2,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000},
            '{4'd3,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0},
            '{4'd4,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0},
            '{4'd5,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h000F_000F},
            '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{4'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
            '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'd8,  32'h0000_0024, 32'h0000_0003, 32'h0000_0030},
            '{4'd9,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000},
            '{4'd10, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000},
            '{4'd10, 32'h0000_0004, 32'h4000_0000, 32'h0400_0000},
            '{4'd11, 32'h0000_0000, 32'hABCD_1234, 32'h1234_0000}
        };
        for (int i = 0; i < 15; i++) begin
            drive_alu(v[i].op, v[i].a, v[i].b);
            step();
            checks++;
            if (alu_res_o !== v[i].e || wr_reg_o !== 5'd3 || regwr_o !== 1'b1) begin
                errors++;
                $display("FAIL alu_op%0d vec%0d got %h reg=%0d exp %h reg=3", v[i].op, i, alu_res_o, wr_reg_o, v[i].e);
            end
        end
    endtask

    task automatic test_src_select();
        idle_inputs();
        aluop_i = 4'd0; alusrca_i = 2'd1; alusrcb_i = 2'd1; shamt_i = 5'd3; imm_i = 32'd5;
        rs_data_i = 32'h100; rt_data_i = 32'h200;
        step();
        checks++;
        if (alu_res_o !== 32'd8) begin
            errors++;
            $display("FAIL src_shamt_imm got %h exp 8", alu_res_o);
        end
        alusrca_i = 2'd2; alusrcb_i = 2'd2; pc4_i = 32'h0000_0100;
        step();
        checks++;
        if (alu_res_o !== 32'h104) begin
            errors++;
            $display("FAIL src_pc4_four got %h exp 104", alu_res_o);
        end
        alusrca_i = 2'd3; alusrcb_i = 2'd3;
        step();
        checks++;
        if (alu_res_o !== 32'd0) begin
            errors++;
            $display("FAIL src_zero got %h exp 0", alu_res_o);
        end
    endtask

    task automatic test_flush();
        drive_alu(4'd0, 32'd9, 32'd9);
        mem2reg_i = 1'b1; memwr_i = 1'b1; flush_i = 1'b1;
        step();
        checks++;
        if ({alu_res_o, st_data_o, wr_reg_o, mem2reg_o, regwr_o, memwr_o} !== '0) begin
            errors++;
            $display("FAIL flush_bubble got res=%h st=%h reg=%0d ctl=%b%b%b exp all 0",
                     alu_res_o, st_data_o, wr_reg_o, mem2reg_o, regwr_o, memwr_o);
        end
    endtask

    task automatic test_multu();
        drive_alu(4'd12, 32'hFFFF_FFFF, 32'd2);
        regwr_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL multu_stall got %b exp 0", stall_o);
        end
        step();
        drive_alu(4'd14, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'd1) begin
            errors++;
            $display("FAIL multu_hi got %h exp 1", alu_res_o);
        end
        drive_alu(4'd12, 32'd3, 32'd3);
        flush_i = 1'b1;
        step();
        drive_alu(4'd15, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_lo_after_flush got %h exp fffffffe", alu_res_o);
        end
        drive_alu(4'd12, 32'd5, 32'd6);
        step();
        drive_alu(4'd15, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'd30) begin
            errors++;
            $display("FAIL multu_next_insn got %h exp 1e", alu_res_o);
        end
    endtask

`ifdef EX_DIV_EN
    task automatic run_divu(input logic [31:0] a, input logic [31:0] b, output int stalls);
        drive_alu(4'd13, a, b);
        regwr_i = 1'b0; rd_i = 5'd9;
        #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 100) begin
            stalls++;
            step();
            if (regwr_o !== 1'b0 || wr_reg_o !== 5'd0) begin
                checks++;
                errors++;
                $display("FAIL divu_bubble got reg=%0d regwr=%b exp 0/0", wr_reg_o, regwr_o);
            end
        end
        step();
    endtask

    task automatic test_divu();
        int stalls;
        run_divu(32'd100, 32'd7, stalls);
        checks++;
        if (stalls != 33 || wr_reg_o !== 5'd9) begin
            errors++;
            $display("FAIL divu_stall_len got %0d reg=%0d exp 33 reg=9", stalls, wr_reg_o);
        end
        drive_alu(4'd15, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'd14) begin
            errors++;
            $display("FAIL divu_lo got %h exp e", alu_res_o);
        end
        drive_alu(4'd14, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'd2) begin
            errors++;
            $display("FAIL divu_hi got %h exp 2", alu_res_o);
        end
        drive_alu(4'd13, 32'd1000, 32'd3);
        step();
        repeat (10) step();
        flush_i = 1'b1;
        step();
        drive_alu(4'd15, 32'd0, 32'd0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL divu_flush_stall got %b exp 0", stall_o);
        end
        step();
        checks++;
        if (alu_res_o !== 32'd14) begin
            errors++;
            $display("FAIL divu_flush_lo got %h exp e", alu_res_o);
        end
        run_divu(32'h1234_5678, 32'd0, stalls);
        drive_alu(4'd15, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_zero_lo got %h exp ffffffff", alu_res_o);
        end
        drive_alu(4'd14, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL divu_zero_hi got %h exp 12345678", alu_res_o);
        end
    endtask
`else
    task automatic test_divu();
        drive_alu(4'd13, 32'd100, 32'd7);
        rd_i = 5'd9;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL divu_nostall got %b exp 0", stall_o);
        end
        step();
        checks++;
        if (wr_reg_o !== 5'd9 || regwr_o !== 1'b1) begin
            errors++;
            $display("FAIL divu_advance got reg=%0d regwr=%b exp 9/1", wr_reg_o, regwr_o);
        end
        drive_alu(4'd15, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'd30) begin
            errors++;
            $display("FAIL divu_lo_unchanged got %h exp 1e", alu_res_o);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive_alu(4'd12, 32'd7, 32'd7);
        step();
        drive_alu(4'd13, 32'd100, 32'd7);
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_res_o, st_data_o, wr_reg_o, mem2reg_o, regwr_o, memwr_o, stall_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid got res=%h reg=%0d stall=%b exp all 0", alu_res_o, wr_reg_o, stall_o);
        end
        step();
        drive_alu(4'd15, 32'd0, 32'd0);
        rst = 1'b0;
        step();
        checks++;
        if (alu_res_o !== 32'd0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_lo got %h stall=%b exp 0/0", alu_res_o, stall_o);
        end
        drive_alu(4'd14, 32'd0, 32'd0);
        step();
        checks++;
        if (alu_res_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_hi got %h exp 0", alu_res_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_add();
        test_forwarding();
        test_alu_ops();
        test_src_select();
        test_flush();
        test_multu();
        test_divu();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
